// File: rtl/key_pkg.sv
// Shared constants and width helpers for the key debounce array.
package key_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEF   = 4;
  localparam int unsigned LONG_PRESS_CYCLES_DEF = 16;

  // Pin level seen when the key is not pressed.
  function automatic logic idle_level(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

  // Debounce counter width; must hold values up to debounce_cycles.
  function automatic int unsigned cnt_w(input int unsigned debounce_cycles);
    return $clog2(debounce_cycles + 1);
  endfunction

  // Hold counter width; must hold values up to long_press_cycles.
  function automatic int unsigned hold_w(input int unsigned long_press_cycles);
    return $clog2(long_press_cycles + 1);
  endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One key channel: 2-flop synchroniser, debounce counter, hold counter,
// press/release/long-press pulses and a toggle flag.
module key_debounce_chan
  import key_pkg::*;
#(
  parameter bit          ACTIVE_LOW        = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEF,
  parameter bit          TOGGLE_ON_RELEASE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_en,
  input  logic key_pin,
  input  logic toggle_clr,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press_pulse,
  output logic toggle_state
);

  localparam int unsigned CNT_W  = cnt_w(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_W = hold_w(LONG_PRESS_CYCLES);
  localparam logic        IDLE   = idle_level(ACTIVE_LOW);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  logic              sync1_q, sync2_q, raw;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              level_q, level_d;
  logic              press_q, release_q, long_q, toggle_q;
  logic              press_d, release_d, long_d, toggle_d, flip;

  // Synchroniser; resets to the idle pin level so reset release is never a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= IDLE;
      sync2_q <= IDLE;
    end else begin
      sync1_q <= key_pin;
      sync2_q <= sync1_q;
    end
  end

  assign raw = sync2_q ^ ACTIVE_LOW;

  // Debounce: a new level must persist for DEBOUNCE_CYCLES enabled samples.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sample_en) begin
      if (raw == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        level_d = raw;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Hold counter saturates so the long-press pulse fires once per press.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (!level_q) begin
      hold_d = '0;
    end else if (sample_en && hold_q != HOLD_MAX) begin
      hold_d = hold_q + HOLD_W'(1);
      long_d = (hold_q == HOLD_LAST);
    end
  end

  // Edge pulses and toggle; clear beats a simultaneous flip.
  always_comb begin
    press_d   = level_d & ~level_q;
    release_d = ~level_d & level_q;
    flip      = TOGGLE_ON_RELEASE ? release_q : press_q;
    toggle_d  = toggle_clr ? 1'b0 : (toggle_q ^ flip);
  end

  // Channel state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      hold_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      toggle_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      toggle_q  <= toggle_d;
    end
  end

  assign key_level        = level_q;
  assign press_pulse      = press_q;
  assign release_pulse    = release_q;
  assign long_press_pulse = long_q;
  assign toggle_state     = toggle_q;

endmodule

// File: rtl/key_debounce_array.sv
// Multi-channel push-button conditioner: N_KEYS independent debounce channels.
module key_debounce_array
  import key_pkg::*;
#(
  parameter int unsigned N_KEYS            = 4,
  parameter bit          ACTIVE_LOW        = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEF,
  parameter bit          TOGGLE_ON_RELEASE = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_en,
  input  logic [N_KEYS-1:0] key_in,
  input  logic [N_KEYS-1:0] toggle_clr,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] long_press_pulse,
  output logic [N_KEYS-1:0] toggle_state
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    key_debounce_chan #(
      .ACTIVE_LOW        (ACTIVE_LOW),
      .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES),
      .TOGGLE_ON_RELEASE (TOGGLE_ON_RELEASE)
    ) u_chan (
      .clk              (clk),
      .rst              (rst),
      .sample_en        (sample_en),
      .key_pin          (key_in[i]),
      .toggle_clr       (toggle_clr[i]),
      .key_level        (key_level[i]),
      .press_pulse      (press_pulse[i]),
      .release_pulse    (release_pulse[i]),
      .long_press_pulse (long_press_pulse[i]),
      .toggle_state     (toggle_state[i])
    );
  end

endmodule

// File: tb/tb_key_debounce_array.sv
// Self-checking bench for key_debounce_array with a window-based reference model.
module tb_key_debounce_array;

  localparam int N = 4;
  localparam int D = 4;
  localparam int L = 16;

  logic       clk, rst, sample_en;
  logic [3:0] key_in, toggle_clr;
  logic [3:0] key_level, press_pulse, release_pulse, long_press_pulse, toggle_state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit div4   = 0;
  bit chk_en = 0;

  // Reference model state (pressed = 1 convention).
  logic [3:0] e_level, e_press, e_rel, e_long, e_tog;
  logic [3:0] d1, d2;
  logic [3:0] win [N];
  int         nwin [N];
  int         held [N];

  key_debounce_array #(
    .N_KEYS            (4),
    .ACTIVE_LOW        (1'b1),
    .DEBOUNCE_CYCLES   (D),
    .LONG_PRESS_CYCLES (L),
    .TOGGLE_ON_RELEASE (1'b0)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .sample_en        (sample_en),
    .key_in           (key_in),
    .toggle_clr       (toggle_clr),
    .key_level        (key_level),
    .press_pulse      (press_pulse),
    .release_pulse    (release_pulse),
    .long_press_pulse (long_press_pulse),
    .toggle_state     (toggle_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    e_level = '0; e_press = '0; e_rel = '0; e_long = '0; e_tog = '0;
    d1 = '0; d2 = '0;
    for (int c = 0; c < N; c++) begin
      win[c]  = '0;
      nwin[c] = 0;
      held[c] = 0;
    end
  endtask

  // A level change is accepted once the last D enabled samples all show the other level.
  task automatic model_step();
    logic       raw, nt;
    logic [3:0] pin_pr;
    pin_pr = ~key_in;
    for (int c = 0; c < N; c++) begin
      raw   = d2[c];
      d2[c] = d1[c];
      d1[c] = pin_pr[c];
      nt = e_tog[c] ^ e_press[c];
      if (toggle_clr[c]) nt = 1'b0;
      e_press[c] = 1'b0;
      e_rel[c]   = 1'b0;
      e_long[c]  = 1'b0;
      if (sample_en) begin
        if (e_level[c]) begin
          if (held[c] < L) begin
            held[c]++;
            if (held[c] == L) e_long[c] = 1'b1;
          end
        end else begin
          held[c] = 0;
        end
        win[c] = {win[c][2:0], raw};
        if (nwin[c] < D) nwin[c]++;
        if (nwin[c] == D && win[c] == {4{~e_level[c]}}) begin
          e_level[c] = ~e_level[c];
          e_press[c] = e_level[c];
          e_rel[c]   = ~e_level[c];
        end
      end
      e_tog[c] = nt;
    end
  endtask

  // Model advances on every clock edge and resets asynchronously with the DUT.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Compare every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk4("key_level", key_level, e_level);
        chk4("press_pulse", press_pulse, e_press);
        chk4("release_pulse", release_pulse, e_rel);
        chk4("long_press_pulse", long_press_pulse, e_long);
        chk4("toggle_state", toggle_state, e_tog);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      cyc++;
      sample_en = div4 ? (cyc % 4 == 0) : 1'b1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(2);
  endtask

  initial begin
    rst        = 1'b1;
    sample_en  = 1'b1;
    key_in     = 4'hF;
    toggle_clr = 4'h0;
    cycles(2);
    rst = 1'b0;
    chk_en = 1'b1;
    cycles(2);
    chk4("reset key_level", key_level, 4'h0);
    chk4("reset toggle_state", toggle_state, 4'h0);

    // Clean press on key 0.
    key_in[0] = 1'b0;
    cycles(5);
    chk1("k0 level before latency", key_level[0], 1'b0);
    cycles(1);
    chk1("k0 level at latency", key_level[0], 1'b1);
    chk1("k0 press pulse", press_pulse[0], 1'b1);
    cycles(1);
    chk1("k0 press pulse width", press_pulse[0], 1'b0);
    chk1("k0 toggle", toggle_state[0], 1'b1);
    cycles(14);
    chk1("k0 long before", long_press_pulse[0], 1'b0);
    cycles(1);
    chk1("k0 long at 16", long_press_pulse[0], 1'b1);
    cycles(1);
    chk1("k0 long width", long_press_pulse[0], 1'b0);
    cycles(2);
    key_in[0] = 1'b1;
    cycles(20);

    // Bounce on key 1: 3 low, 2 high, 3 low.
    key_in[1] = 1'b0; cycles(3);
    key_in[1] = 1'b1; cycles(2);
    key_in[1] = 1'b0; cycles(3);
    key_in[1] = 1'b1;
    cycles(15);
    chk1("k1 bounce level", key_level[1], 1'b0);

    // Release and toggle on key 2.
    key_in[2] = 1'b0; cycles(10);
    chk1("k2 toggle after press", toggle_state[2], 1'b1);
    key_in[2] = 1'b1; cycles(10);
    chk1("k2 level after release", key_level[2], 1'b0);
    key_in[2] = 1'b0; cycles(10);
    chk1("k2 toggle after 2nd press", toggle_state[2], 1'b0);
    key_in[2] = 1'b1;
    cycles(20);
    do_reset();

    // Simultaneous press on keys 0 and 3, clear of key 3 toggle in the pulse cycle.
    key_in = 4'b0110;
    cycles(6);
    chk4("simul press pulses", press_pulse, 4'b1001);
    toggle_clr = 4'b1000;
    cycles(1);
    toggle_clr = 4'b0000;
    chk4("simul toggle", toggle_state, 4'b0001);
    key_in = 4'hF;
    cycles(20);
    do_reset();

    // Reset mid-debounce (key 0) and mid-hold (key 1).
    key_in[1] = 1'b0;
    cycles(12);
    key_in[0] = 1'b0;
    cycles(4);
    chk1("k1 held before reset", key_level[1], 1'b1);
    rst = 1'b1;
    #1;
    chk4("async rst key_level", key_level, 4'h0);
    chk4("async rst press", press_pulse, 4'h0);
    chk4("async rst release", release_pulse, 4'h0);
    chk4("async rst long", long_press_pulse, 4'h0);
    chk4("async rst toggle", toggle_state, 4'h0);
    key_in = 4'hF;
    cycles(2);
    rst = 1'b0;
    cycles(50);

    // Sparse sampling: 12-clk press rejected, 20-clk press accepted.
    div4 = 1'b1;
    key_in[0] = 1'b0; cycles(12);
    key_in[0] = 1'b1; cycles(30);
    chk1("div4 short press rejected", key_level[0], 1'b0);
    key_in[0] = 1'b0; cycles(20);
    chk1("div4 long press accepted", key_level[0], 1'b1);
    key_in[0] = 1'b1; cycles(40);
    div4 = 1'b0;
    cycles(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
